// File: rtl/clk_en_gen_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clk_en_pkg;

    // Ratio loaded into every channel out of reset (27 MHz -> 9 MHz enable).
    localparam int DEF_MUL_C      = 1;
    localparam int DEF_DIV_C      = 3;
    localparam int DEF_SETTLE_C   = 16;
    localparam int DEF_RATIO_W_C  = 16;
    localparam int DEF_CHANNELS_C = 2;

    // Width of a channel index; a single channel still gets one select bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A ratio is usable when 1 <= M <= D (this also rejects D == 0).
    function automatic logic valid_ratio(input logic [31:0] m, input logic [31:0] d);
        return (m != 32'd0) && (m <= d);
    endfunction

endpackage

// File: rtl/clk_en_gen_multi_if.sv
// Configuration port of the clock-enable generator: valid/ready request
// carrying channel index and M/D ratio, plus a one-cycle reject pulse.
interface clk_en_gen_multi_if #(
    parameter int CHANNELS = 2,
    parameter int RATIO_W  = 16
);
    localparam int CH_W = clk_en_pkg::chan_w(CHANNELS);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [RATIO_W-1:0] cfg_mul;
    logic [RATIO_W-1:0] cfg_div;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mul, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mul, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clk_en_chan.sv
// One enable channel: M/D ratio registers, fractional accumulator, settle
// counter gating lock, registered enable pulse and companion square wave.
module clk_en_chan #(
    parameter int RATIO_W = 16,
    parameter int SETTLE  = 16,
    parameter int DEF_MUL = 1,
    parameter int DEF_DIV = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [RATIO_W-1:0] i_mul,
    input  logic [RATIO_W-1:0] i_div,
    output logic               o_ce,
    output logic               o_clk_sq,
    output logic               o_lock
);
    // Counter only has to reach SETTLE-1; lock covers the final cycle.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [RATIO_W-1:0] r_mul;
    logic [RATIO_W-1:0] r_div;
    logic [RATIO_W-1:0] r_acc;
    logic [SW-1:0]      r_settle;
    logic               r_ce;
    logic               r_sq;
    logic               r_lock;

    logic [RATIO_W:0]   w_sum;
    logic [RATIO_W:0]   w_wrap;
    logic               w_hit;

    // One extra bit on the sum so acc + M never wraps before the compare.
    always_comb begin
        w_sum  = {1'b0, r_acc} + {1'b0, r_mul};
        w_wrap = w_sum - {1'b0, r_div};
        w_hit  = (w_sum >= {1'b0, r_div});
    end

    // Channel state: reset/load restart settling, then accumulate when locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul    <= RATIO_W'(DEF_MUL);
            r_div    <= RATIO_W'(DEF_DIV);
            r_acc    <= '0;
            r_settle <= '0;
            r_lock   <= 1'b0;
            r_ce     <= 1'b0;
            r_sq     <= 1'b0;
        end else if (i_load) begin
            // clk_sq deliberately keeps its level across a reprogram.
            r_mul    <= i_mul;
            r_div    <= i_div;
            r_acc    <= '0;
            r_settle <= '0;
            r_lock   <= 1'b0;
            r_ce     <= 1'b0;
        end else if (!r_lock) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
            if (r_settle == SW'(SETTLE - 1)) begin
                r_lock <= 1'b1;
            end else begin
                r_settle <= r_settle + 1'b1;
            end
        end else if (w_hit) begin
            // acc < D and M <= D keep the remainder inside RATIO_W bits.
            r_acc <= w_wrap[RATIO_W-1:0];
            r_ce  <= 1'b1;
            r_sq  <= ~r_sq;
        end else begin
            r_acc <= w_sum[RATIO_W-1:0];
            r_ce  <= 1'b0;
        end
    end

    assign o_ce     = r_ce;
    assign o_clk_sq = r_sq;
    assign o_lock   = r_lock;

endmodule

// File: rtl/clk_en_gen_multi.sv
// Multi-channel clock-enable generator: config decode, reject flag and an
// array of independent enable channels.
module clk_en_gen_multi
    import clk_en_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS_C,
    parameter int RATIO_W  = DEF_RATIO_W_C,
    parameter int SETTLE   = DEF_SETTLE_C,
    parameter int DEF_MUL  = DEF_MUL_C,
    parameter int DEF_DIV  = DEF_DIV_C
) (
    input  logic                clk,
    input  logic                rst,
    clk_en_gen_multi_if.slave   cfg,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] clk_sq,
    output logic [CHANNELS-1:0] lock
);
    logic                w_xfer;
    logic                w_ok;
    logic [CHANNELS-1:0] w_load;
    logic                r_err;

    // Always ready outside reset; the accept is purely the handshake.
    assign cfg.cfg_ready = ~rst;
    assign cfg.cfg_err   = r_err;

    // Request is honoured only for a legal ratio aimed at an existing channel.
    always_comb begin
        w_xfer = cfg.cfg_valid & ~rst;
        w_ok   = valid_ratio(32'(cfg.cfg_mul), 32'(cfg.cfg_div)) &&
                 (32'(cfg.cfg_ch) < 32'(CHANNELS));
    end

    // Rejected transfer raises cfg_err for exactly the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_ok;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_load[gi] = w_xfer && w_ok && (32'(cfg.cfg_ch) == 32'(gi));

            clk_en_chan #(
                .RATIO_W (RATIO_W),
                .SETTLE  (SETTLE),
                .DEF_MUL (DEF_MUL),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_load[gi]),
                .i_mul    (cfg.cfg_mul),
                .i_div    (cfg.cfg_div),
                .o_ce     (ce[gi]),
                .o_clk_sq (clk_sq[gi]),
                .o_lock   (lock[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// Bench for clk_en_gen_multi: per-cycle reference model of every channel,
// cfg_err scoreboard, a config vector table and hand-written corner cases.
module tb_clk_en_gen_multi;
    import clk_en_pkg::*;

    localparam int CH  = 2;
    localparam int RW  = 16;
    localparam int ST  = 16;
    localparam int CHW = chan_w(CH);
    localparam int CH3 = 3;
    localparam int CHW3 = chan_w(CH3);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_en_gen_multi_if #(.CHANNELS(CH), .RATIO_W(RW)) cfg_if ();
    logic [CH-1:0] ce, clk_sq, lock;

    clk_en_gen_multi #(
        .CHANNELS(CH), .RATIO_W(RW), .SETTLE(ST), .DEF_MUL(1), .DEF_DIV(3)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if.slave),
        .ce(ce), .clk_sq(clk_sq), .lock(lock)
    );

    // Three-channel instance so an out-of-range channel index is encodable.
    clk_en_gen_multi_if #(.CHANNELS(CH3), .RATIO_W(RW)) cfg3_if ();
    logic [CH3-1:0] ce3, sq3, lock3;

    clk_en_gen_multi #(
        .CHANNELS(CH3), .RATIO_W(RW), .SETTLE(4), .DEF_MUL(1), .DEF_DIV(3)
    ) dut3 (
        .clk(clk), .rst(rst), .cfg(cfg3_if.slave),
        .ce(ce3), .clk_sq(sq3), .lock(lock3)
    );

    int vectors     = 0;
    int miscompares = 0;

    bit exp_err_q[$];
    logic drv_bad = 1'b0;

    longint m_mul [CH];
    longint m_div [CH];
    longint m_unl [CH];
    longint m_n   [CH];
    bit     m_lock[CH];
    bit     m_ce  [CH];
    bit     m_sq  [CH];

    typedef struct {
        int ch;
        int mul;
        int div;
        bit bad;
        int hold;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare every output shortly after it.
    task automatic step();
        bit     s_rst, s_xfer, s_bad;
        int     s_ch;
        longint s_m, s_d;
        s_rst  = rst;
        s_xfer = cfg_if.cfg_valid && !rst;
        s_bad  = drv_bad;
        s_ch   = int'(cfg_if.cfg_ch);
        s_m    = longint'(cfg_if.cfg_mul);
        s_d    = longint'(cfg_if.cfg_div);
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            if (s_rst) begin
                m_mul[c] = 1; m_div[c] = 3; m_unl[c] = 0; m_n[c] = 0;
                m_lock[c] = 0; m_ce[c] = 0; m_sq[c] = 0;
            end else if (s_xfer && !s_bad && s_ch == c) begin
                m_mul[c] = s_m; m_div[c] = s_d; m_unl[c] = 0; m_n[c] = 0;
                m_lock[c] = 0; m_ce[c] = 0;
            end else if (!m_lock[c]) begin
                m_unl[c]++;
                m_ce[c] = 0;
                if (m_unl[c] == ST) m_lock[c] = 1;
            end else begin
                // n-th locked cycle fires when floor(n*M/D) steps up.
                m_n[c]++;
                m_ce[c] = ((m_n[c] * m_mul[c]) / m_div[c]) !=
                          (((m_n[c] - 1) * m_mul[c]) / m_div[c]);
                if (m_ce[c]) m_sq[c] = !m_sq[c];
            end
        end
        exp_err_q.push_back(!s_rst && s_xfer && s_bad);
        #1;
        check("cfg_err", longint'(cfg_if.cfg_err), longint'(exp_err_q.pop_front()));
        check("cfg_ready", longint'(cfg_if.cfg_ready), longint'(!rst));
        for (int c = 0; c < CH; c++) begin
            check($sformatf("ce[%0d]", c), longint'(ce[c]), longint'(m_ce[c]));
            check($sformatf("lock[%0d]", c), longint'(lock[c]), longint'(m_lock[c]));
            check($sformatf("clk_sq[%0d]", c), longint'(clk_sq[c]), longint'(m_sq[c]));
        end
    endtask

    task automatic send(input int ch, input int mul, input int div, input bit bad);
        $display("cfg ch=%0d M=%0d D=%0d expect_err=%0d", ch, mul, div, bad);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CHW'(ch);
        cfg_if.cfg_mul   = RW'(mul);
        cfg_if.cfg_div   = RW'(div);
        drv_bad          = bad;
        step();
        cfg_if.cfg_valid = 1'b0;
        drv_bad          = 1'b0;
    endtask

    // Edges until lock[c] rises; 0 means it never did within the budget.
    task automatic wait_lock(input int c, output int edges);
        edges = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (lock[c]) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic count_ce(input int c, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            cnt += int'(ce[c]);
        end
    endtask

    initial begin
        int e;
        int cnt;

        tbl[0] = '{ch: 1, mul: 5, div: 8, bad: 0, hold: 40};
        tbl[1] = '{ch: 1, mul: 7, div: 7, bad: 0, hold: 30};
        tbl[2] = '{ch: 0, mul: 0, div: 4, bad: 1, hold: 4};
        tbl[3] = '{ch: 1, mul: 9, div: 4, bad: 1, hold: 4};
        tbl[4] = '{ch: 0, mul: 3, div: 0, bad: 1, hold: 4};
        tbl[5] = '{ch: 0, mul: 5, div: 8, bad: 0, hold: 40};

        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_mul    = '0;
        cfg_if.cfg_div    = '0;
        cfg3_if.cfg_valid = 1'b0;
        cfg3_if.cfg_ch    = '0;
        cfg3_if.cfg_mul   = '0;
        cfg3_if.cfg_div   = '0;

        // Power-up reset and default ratio 1/3.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_lock(0, e);
        check("lock0_rise_edge", e, 16);
        count_ce(0, 1000, cnt);
        check("ce0_in_1000_is_333_or_334", longint'(cnt == 333 || cnt == 334), 1);
        $display("default cadence: %0d ce in 1000 locked cycles", cnt);

        // Table of config requests, model checks every cycle of each hold.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].ch, tbl[i].mul, tbl[i].div, tbl[i].bad);
            repeat (tbl[i].hold) step();
        end

        // 5/8 on ch1: lock 16 edges after transfer, 5 ce in every 8 cycles.
        send(1, 5, 8, 0);
        wait_lock(1, e);
        check("ch1_5_8_lock_edge", e, 16);
        for (int w = 0; w < 3; w++) begin
            count_ce(1, 8, cnt);
            check($sformatf("ch1_5_8_window%0d", w), cnt, 5);
        end

        // M == D: enable every locked cycle.
        send(1, 7, 7, 0);
        wait_lock(1, e);
        check("ch1_7_7_lock_edge", e, 16);
        count_ce(1, 10, cnt);
        check("ch1_7_7_ce_in_10", cnt, 10);

        // One-cycle reset while ch0 runs 5/8.
        $display("mid-stream reset");
        rst = 1'b1;
        step();
        check("rst_ce", longint'(ce), 0);
        check("rst_lock", longint'(lock), 0);
        check("rst_clk_sq", longint'(clk_sq), 0);
        rst = 1'b0;
        wait_lock(0, e);
        check("post_rst_lock_edge", e, 16);
        count_ce(0, 9, cnt);
        check("post_rst_default_ce_in_9", cnt, 3);

        // Back-to-back configs to ch0: last one wins, settle restarts.
        send(0, 1, 2, 0);
        send(0, 1, 4, 0);
        wait_lock(0, e);
        check("b2b_lock_edge", e, 16);
        count_ce(0, 8, cnt);
        check("b2b_ce_in_8", cnt, 2);

        // Channel index beyond CHANNELS on the three-channel instance.
        check("dut3_locked", longint'(lock3), 7);
        $display("cfg3 ch=3 M=1 D=3 expect_err=1");
        cfg3_if.cfg_valid = 1'b1;
        cfg3_if.cfg_ch    = CHW3'(3);
        cfg3_if.cfg_mul   = RW'(1);
        cfg3_if.cfg_div   = RW'(3);
        step();
        cfg3_if.cfg_valid = 1'b0;
        check("dut3_bad_ch_err", longint'(cfg3_if.cfg_err), 1);
        check("dut3_bad_ch_lock", longint'(lock3), 7);
        step();
        check("dut3_err_one_cycle", longint'(cfg3_if.cfg_err), 0);
        $display("cfg3 ch=2 M=1 D=2 expect_err=0");
        cfg3_if.cfg_valid = 1'b1;
        cfg3_if.cfg_ch    = CHW3'(2);
        cfg3_if.cfg_mul   = RW'(1);
        cfg3_if.cfg_div   = RW'(2);
        step();
        cfg3_if.cfg_valid = 1'b0;
        check("dut3_good_ch_err", longint'(cfg3_if.cfg_err), 0);
        check("dut3_good_ch_lock", longint'(lock3), 3);

        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
